regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb_if.sv | 29 ++
 rtl/regfile_sb.sv | 97 +++++++++
 tb/tb_regfile_sb.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
// Register-file / scoreboard bus: read ports, write ports, issue handshake and flush.
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 3,
  parameter int NUM_WR = 2
);
  logic [NUM_RD*ADDR_W-1:0] RdAddr;
  logic [NUM_RD*DATA_W-1:0] RdData;
  logic [NUM_RD-1:0]        RdBusy;
  logic [NUM_WR-1:0]        WrEn;
  logic [NUM_WR*ADDR_W-1:0] WrAddr;
  logic [NUM_WR*DATA_W-1:0] WrData;
  logic                     IssueValid;
  logic [ADDR_W-1:0]        IssueAddr;
  logic                     IssueReady;
  logic                     Flush;
  logic [ADDR_W:0]          BusyCount;

  modport master (
    output RdAddr, WrEn, WrAddr, WrData, IssueValid, IssueAddr, Flush,
    input  RdData, RdBusy, IssueReady, BusyCount
  );

  modport slave (
    input  RdAddr, WrEn, WrAddr, WrData, IssueValid, IssueAddr, Flush,
    output RdData, RdBusy, IssueReady, BusyCount
  );
endinterface

// File: rtl/regfile_sb.sv
// Multi-port register file with per-register busy scoreboard, write bypass and flush.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 3,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input logic          CLK,
  input logic          RESET,
  regfile_sb_if.slave  bus
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]        regMem [DEPTH];
  logic [DEPTH-1:0]         busy;
  logic [DEPTH-1:0]         busyNext;
  logic [DEPTH-1:0]         wrHitVec;
  logic [ADDR_W:0]          busyCount;
  logic [NUM_RD*DATA_W-1:0] rdData;
  logic [NUM_RD-1:0]        rdBusy;
  logic                     issueReady;
  logic                     issueAccept;

  function automatic logic isZero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  function automatic logic [ADDR_W:0] popCount(input logic [DEPTH-1:0] v);
    logic [ADDR_W:0] cnt;
    cnt = '0;
    for (int k = 0; k < DEPTH; k++)
      cnt = cnt + {{ADDR_W{1'b0}}, v[k]};
    return cnt;
  endfunction

  // Registers receiving a real write this cycle (index 0 excluded when hardwired).
  always_comb begin
    wrHitVec = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (bus.WrEn[j] && !isZero(bus.WrAddr[j*ADDR_W +: ADDR_W]))
        wrHitVec[bus.WrAddr[j*ADDR_W +: ADDR_W]] = 1'b1;
    end
  end

  // Read ports; later write ports overwrite earlier ones so the highest index wins.
  always_comb begin
    rdData = '0;
    rdBusy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      a = bus.RdAddr[i*ADDR_W +: ADDR_W];
      d = regMem[a];
      for (int j = 0; j < NUM_WR; j++) begin
        if (bus.WrEn[j] && (bus.WrAddr[j*ADDR_W +: ADDR_W] == a))
          d = bus.WrData[j*DATA_W +: DATA_W];
      end
      if (isZero(a))
        d = '0;
      rdData[i*DATA_W +: DATA_W] = d;
      rdBusy[i] = busy[a] & ~wrHitVec[a];
    end
  end

  always_comb begin
    issueReady  = !bus.Flush && (!busy[bus.IssueAddr] || wrHitVec[bus.IssueAddr]);
    issueAccept = bus.IssueValid && issueReady && !isZero(bus.IssueAddr);
    busyNext    = busy & ~wrHitVec;
    // A new producer issued alongside the old producer's write keeps the bit set.
    if (issueAccept)
      busyNext[bus.IssueAddr] = 1'b1;
    if (bus.Flush)
      busyNext = '0;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int k = 0; k < DEPTH; k++)
        regMem[k] <= '0;
      busy      <= '0;
      busyCount <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (bus.WrEn[j] && !isZero(bus.WrAddr[j*ADDR_W +: ADDR_W]))
          regMem[bus.WrAddr[j*ADDR_W +: ADDR_W]] <= bus.WrData[j*DATA_W +: DATA_W];
      end
      busy      <= busyNext;
      busyCount <= popCount(busyNext);
    end
  end

  assign bus.RdData     = rdData;
  assign bus.RdBusy     = rdBusy;
  assign bus.IssueReady = issueReady;
  assign bus.BusyCount  = busyCount;
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: array/flag model checked every cycle plus directed literal checks.
module tb_regfile_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 3;
  localparam int NW = 2;
  localparam int DEPTH = 32;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int compared = 0;
  int mismatched = 0;
  bit checkOn = 1'b0;

  regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) bus ();

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(1)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  logic [DW-1:0] modelReg [DEPTH];
  bit            modelBusy [DEPTH];

  function automatic bit wrHit(input logic [AW-1:0] a, output logic [DW-1:0] d);
    bit hit;
    hit = 1'b0;
    d = '0;
    for (int j = 0; j < NW; j++) begin
      if (bus.WrEn[j] && bus.WrAddr[j*AW +: AW] == a) begin
        hit = 1'b1;
        d = bus.WrData[j*DW +: DW];
      end
    end
    return hit;
  endfunction

  function automatic bit expReady();
    logic [DW-1:0] d;
    bit h;
    h = wrHit(bus.IssueAddr, d);
    if (bus.Flush) return 1'b0;
    if (bus.IssueAddr == 0) return 1'b1;
    return !modelBusy[bus.IssueAddr] || h;
  endfunction

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int k = 0; k < DEPTH; k++) begin
        modelReg[k] = '0;
        modelBusy[k] = 1'b0;
      end
    end else begin
      bit acc;
      acc = bus.IssueValid && expReady() && bus.IssueAddr != 0;
      for (int j = 0; j < NW; j++) begin
        if (bus.WrEn[j] && bus.WrAddr[j*AW +: AW] != 0) begin
          modelReg[bus.WrAddr[j*AW +: AW]] = bus.WrData[j*DW +: DW];
          modelBusy[bus.WrAddr[j*AW +: AW]] = 1'b0;
        end
      end
      if (acc) modelBusy[bus.IssueAddr] = 1'b1;
      if (bus.Flush)
        for (int k = 0; k < DEPTH; k++) modelBusy[k] = 1'b0;
    end
  end

  task automatic checkLit(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (checkOn && RESET) begin
      int cnt;
      cnt = 0;
      for (int k = 0; k < DEPTH; k++) cnt += modelBusy[k] ? 1 : 0;
      for (int i = 0; i < NR; i++) begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] expD;
        bit h;
        a = bus.RdAddr[i*AW +: AW];
        h = wrHit(a, d);
        expD = (a == 0) ? '0 : (h ? d : modelReg[a]);
        checkLit($sformatf("model_RdData%0d", i), bus.RdData[i*DW +: DW], expD);
        checkLit($sformatf("model_RdBusy%0d", i), {31'd0, bus.RdBusy[i]},
                 {31'd0, (a != 0) && modelBusy[a] && !h});
      end
      checkLit("model_IssueReady", {31'd0, bus.IssueReady}, {31'd0, expReady()});
      checkLit("model_BusyCount", {26'd0, bus.BusyCount}, cnt);
    end
  end

  task automatic idle();
    bus.WrEn = '0;
    bus.WrAddr = '0;
    bus.WrData = '0;
    bus.IssueValid = 1'b0;
    bus.IssueAddr = '0;
    bus.Flush = 1'b0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic setWr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.WrEn[p] = 1'b1;
    bus.WrAddr[p*AW +: AW] = a;
    bus.WrData[p*DW +: DW] = d;
  endtask

  task automatic setRd(input int p, input logic [AW-1:0] a);
    bus.RdAddr[p*AW +: AW] = a;
  endtask

  task automatic issue(input logic [AW-1:0] a);
    bus.IssueValid = 1'b1;
    bus.IssueAddr = a;
  endtask

  initial begin
    idle();
    bus.RdAddr = '0;
    #1 RESET = 1'b0;
    #2;
    checkLit("reset_BusyCount", {26'd0, bus.BusyCount}, 32'd0);
    checkLit("reset_IssueReady", {31'd0, bus.IssueReady}, 32'd1);
    checkLit("reset_RdData0", bus.RdData[0 +: DW], 32'd0);
    checkLit("reset_RdBusy", {29'd0, bus.RdBusy}, 32'd0);
    #5 RESET = 1'b1;
    checkOn = 1'b1;
    step();

    // write then read, with same-cycle bypass
    setWr(0, 5, 32'hDEADBEEF);
    setRd(0, 5);
    #1 checkLit("bypass_rd5", bus.RdData[0 +: DW], 32'hDEADBEEF);
    step();
    idle();
    #1 checkLit("commit_rd5", bus.RdData[0 +: DW], 32'hDEADBEEF);

    // dual write to one index, and zero register
    setWr(0, 7, 32'h11);
    setWr(1, 7, 32'h22);
    step();
    idle();
    setRd(1, 7);
    #1 checkLit("prio_rd7", bus.RdData[DW +: DW], 32'h22);
    checkLit("model_pin_reg7", modelReg[7], 32'h22);
    setWr(0, 0, 32'h55);
    setRd(2, 0);
    #1 checkLit("zero_bypass", bus.RdData[2*DW +: DW], 32'd0);
    step();
    idle();
    #1 checkLit("zero_commit", bus.RdData[2*DW +: DW], 32'd0);

    // issue, retry blocked, write clears
    issue(3);
    #1 checkLit("issue3_ready", {31'd0, bus.IssueReady}, 32'd1);
    step();
    idle();
    setRd(0, 3);
    #1 checkLit("issue3_count", {26'd0, bus.BusyCount}, 32'd1);
    checkLit("issue3_rdbusy", {31'd0, bus.RdBusy[0]}, 32'd1);
    issue(3);
    #1 checkLit("reissue3_ready", {31'd0, bus.IssueReady}, 32'd0);
    step();
    idle();
    checkLit("reissue3_count", {26'd0, bus.BusyCount}, 32'd1);
    setWr(1, 3, 32'h33);
    #1 checkLit("wr3_rdbusy_bypass", {31'd0, bus.RdBusy[0]}, 32'd0);
    step();
    idle();
    #1 checkLit("wr3_count", {26'd0, bus.BusyCount}, 32'd0);
    checkLit("wr3_data", bus.RdData[0 +: DW], 32'h33);

    // issue and write on same busy index
    issue(9);
    step();
    idle();
    issue(9);
    setWr(0, 9, 32'h99);
    #1 checkLit("iw9_ready", {31'd0, bus.IssueReady}, 32'd1);
    step();
    idle();
    setRd(0, 9);
    #1 checkLit("iw9_data", bus.RdData[0 +: DW], 32'h99);
    checkLit("iw9_busy", {31'd0, bus.RdBusy[0]}, 32'd1);
    checkLit("iw9_count", {26'd0, bus.BusyCount}, 32'd1);

    // flush
    issue(1); step();
    issue(2); step();
    issue(4); step();
    idle();
    #1 checkLit("pre_flush_count", {26'd0, bus.BusyCount}, 32'd4);
    bus.Flush = 1'b1;
    issue(6);
    setWr(0, 10, 32'hA0);
    #1 checkLit("flush_ready", {31'd0, bus.IssueReady}, 32'd0);
    step();
    idle();
    setRd(1, 6);
    setRd(2, 10);
    #1 checkLit("flush_count", {26'd0, bus.BusyCount}, 32'd0);
    checkLit("flush_busy6", {31'd0, bus.RdBusy[1]}, 32'd0);
    checkLit("flush_wr10", bus.RdData[2*DW +: DW], 32'hA0);

    // async reset pulse between edges
    issue(5);
    step();
    idle();
    setRd(0, 5);
    setRd(1, 7);
    setRd(2, 3);
    bus.IssueAddr = 5;
    #1 RESET = 1'b0;
    #1;
    checkLit("rst_rd0", bus.RdData[0 +: DW], 32'd0);
    checkLit("rst_rd1", bus.RdData[DW +: DW], 32'd0);
    checkLit("rst_rd2", bus.RdData[2*DW +: DW], 32'd0);
    checkLit("rst_rdbusy", {29'd0, bus.RdBusy}, 32'd0);
    checkLit("rst_count", {26'd0, bus.BusyCount}, 32'd0);
    checkLit("rst_ready", {31'd0, bus.IssueReady}, 32'd1);
    #1 RESET = 1'b1;
    step();
    checkLit("post_rst_rd0", bus.RdData[0 +: DW], 32'd0);

    // mixed traffic checked against the model each cycle
    for (int n = 0; n < 60; n++) begin
      idle();
      bus.WrEn = NW'($urandom_range(0, 3));
      for (int p = 0; p < NW; p++) begin
        bus.WrAddr[p*AW +: AW] = AW'($urandom_range(0, 11));
        bus.WrData[p*DW +: DW] = $urandom;
      end
      for (int p = 0; p < NR; p++) setRd(p, AW'($urandom_range(0, 11)));
      bus.IssueValid = 1'($urandom_range(0, 1));
      bus.IssueAddr = AW'($urandom_range(0, 11));
      bus.Flush = ($urandom_range(0, 15) == 0);
      step();
    end
    idle();
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
